encap_result_reader: RTL and testbench

Drains encapsulation results after encap_seq_gen asserts done. Reads C0 (l bits), C1 (256 bits) and K (256 bits) through the encap 32-bit read ports. Emits them as one valid/ready word stream in order C0, C1, K. This is the output counterpart of the seed loader: the loader feeds the encap unit, this block reads the ciphertext and session key back out to the host/UART side.

---
 rtl/encap_result_reader_pkg.sv | 61 ++++++
 rtl/encap_result_reader_if.sv | 29 ++
 rtl/encap_result_reader_skid_fifo2.sv | 42 ++++
 rtl/encap_result_reader.sv | 135 +++++++++++++
 tb/tb_encap_result_reader.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/encap_result_reader_pkg.sv
// Shared McEliece parameter mapping, section tags and reader FSM states.
package encap_result_reader_pkg;

    function automatic int m_of(input int ps);
        return (ps == 1) ? 12 : 13;
    endfunction

    function automatic int t_of(input int ps);
        case (ps)
            1:       return 64;
            2:       return 96;
            3:       return 128;
            4:       return 119;
            default: return 128;
        endcase
    endfunction

    function automatic int n_of(input int ps);
        case (ps)
            1:       return 3488;
            2:       return 4608;
            3:       return 6688;
            4:       return 6960;
            default: return 8192;
        endcase
    endfunction

    function automatic int l_of(input int ps);
        return m_of(ps) * t_of(ps);
    endfunction

    function automatic int c0_words_of(input int ps);
        return (l_of(ps) + 31) / 32;
    endfunction

    localparam int C1_WORDS = 8;
    localparam int K_WORDS  = 8;

    localparam logic [1:0] SEL_C0 = 2'd0;
    localparam logic [1:0] SEL_C1 = 2'd1;
    localparam logic [1:0] SEL_K  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_C0 = 3'd1,
        S_RD_C1 = 3'd2,
        S_RD_K  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    typedef struct packed {
        logic        last;
        logic [1:0]  sel;
        logic [31:0] data;
    } word_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/encap_result_reader_if.sv
// Encap result memory read ports plus the outgoing valid/ready word stream.
interface encap_result_reader_if #(parameter int C0_AW = 5);
    logic             rd_C0;
    logic [C0_AW-1:0] C0_addr;
    logic [31:0]      C0_out;
    logic             rd_C1;
    logic [2:0]       C1_addr;
    logic [31:0]      C1_out;
    logic             rd_K;
    logic [2:0]       K_addr;
    logic [31:0]      K_out;
    logic [31:0]      dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [1:0]       dout_sel;
    logic             dout_last;

    modport master (
        output rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr,
        output dout, dout_valid, dout_sel, dout_last,
        input  C0_out, C1_out, K_out, dout_ready
    );

    modport slave (
        input  rd_C0, C0_addr, rd_C1, C1_addr, rd_K, K_addr,
        input  dout, dout_valid, dout_sel, dout_last,
        output C0_out, C1_out, K_out, dout_ready
    );
endinterface

// File: rtl/encap_result_reader_skid_fifo2.sv
// Two-entry skid FIFO for tagged result words; head is presented combinationally.
module skid_fifo2
    import encap_result_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  word_t      push_data,
    input  logic       pop,
    output word_t      head,
    output logic [1:0] count
);
    word_t mem [2];
    logic  wptr, rptr;
    logic  do_push, do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (do_pop)
                rptr <= ~rptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/encap_result_reader.sv
// Reads C0, C1 and K out of the encap unit and streams them as tagged words.
// Build option ENCAP_READER_BSWAP_EN byte-reverses each captured word.
module encap_result_reader
    import encap_result_reader_pkg::*;
#(
    parameter int PARAMETER_SET = 1,
    localparam int C0_WORDS = c0_words_of(PARAMETER_SET),
    localparam int C0_AW    = $clog2(C0_WORDS),
    localparam int CNT_W    = (C0_AW > 3) ? C0_AW : 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    encap_result_reader_if.master bus
);
    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             infl, infl_last, cur_last, done_nx, issue;
    logic [1:0]       infl_sel, cur_sel, count;
    logic             rd_c0, rd_c1, rd_k, pop, can_issue;
    logic [2:0]       occ;
    logic [31:0]      raw, cap_data;
    word_t            head;

    assign pop = bus.dout_valid && bus.dout_ready;
    // Credit the word leaving this cycle so a full-rate stream never bubbles.
    assign occ       = {1'b0, count} - {2'b0, pop} + {2'b0, infl};
    assign can_issue = occ < 3'd2;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        issue    = 1'b0;
        rd_c0    = 1'b0;
        rd_c1    = 1'b0;
        rd_k     = 1'b0;
        cur_sel  = SEL_C0;
        cur_last = 1'b0;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_RD_C0;
                cnt_nx   = '0;
            end
            S_RD_C0: if (can_issue) begin
                issue = 1'b1;
                rd_c0 = 1'b1;
                if (cnt == CNT_W'(C0_WORDS - 1)) begin
                    state_nx = S_RD_C1;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
            end
            S_RD_C1: if (can_issue) begin
                issue   = 1'b1;
                rd_c1   = 1'b1;
                cur_sel = SEL_C1;
                if (cnt == CNT_W'(C1_WORDS - 1)) begin
                    state_nx = S_RD_K;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
            end
            S_RD_K: if (can_issue) begin
                issue   = 1'b1;
                rd_k    = 1'b1;
                cur_sel = SEL_K;
                if (cnt == CNT_W'(K_WORDS - 1)) begin
                    cur_last = 1'b1;
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + 1'b1;
            end
            S_DRAIN: if (!infl && pop && (count == 2'd1)) begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            infl      <= 1'b0;
            infl_sel  <= SEL_C0;
            infl_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            infl      <= issue;
            infl_sel  <= cur_sel;
            infl_last <= cur_last;
            done      <= done_nx;
        end
    end

    always_comb begin
        case (infl_sel)
            SEL_C1:  raw = bus.C1_out;
            SEL_K:   raw = bus.K_out;
            default: raw = bus.C0_out;
        endcase
    end

`ifdef ENCAP_READER_BSWAP_EN
    assign cap_data = bswap32(raw);
`else
    assign cap_data = raw;
`endif

    skid_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl),
        .push_data ('{last: infl_last, sel: infl_sel, data: cap_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign busy           = (state != S_IDLE);
    assign bus.rd_C0      = rd_c0;
    assign bus.rd_C1      = rd_c1;
    assign bus.rd_K       = rd_k;
    assign bus.C0_addr    = (state == S_RD_C0) ? cnt[C0_AW-1:0] : '0;
    assign bus.C1_addr    = (state == S_RD_C1) ? cnt[2:0] : 3'd0;
    assign bus.K_addr     = (state == S_RD_K)  ? cnt[2:0] : 3'd0;
    assign bus.dout       = head.data;
    assign bus.dout_sel   = head.sel;
    assign bus.dout_last  = head.last;
    assign bus.dout_valid = (count != 2'd0);
endmodule

// File: tb/tb_encap_result_reader.sv
// Directed/randomized bench for encap_result_reader against a queue-based stream model.
module tb_encap_result_reader;
    import encap_result_reader_pkg::*;

    localparam int C0W   = c0_words_of(1);
    localparam int C0_AW = $clog2(C0W);
    localparam int NW    = C0W + C1_WORDS + K_WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    encap_result_reader_if #(.C0_AW(C0_AW)) bus ();

    encap_result_reader #(.PARAMETER_SET(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [31:0] c0mem [C0W];
    logic [31:0] c1mem [C1_WORDS];
    logic [31:0] kmem  [K_WORDS];

    // Memory model: data appears one cycle after the read address.
    always @(posedge clk) begin
        if (bus.rd_C0) bus.C0_out <= c0mem[bus.C0_addr];
        if (bus.rd_C1) bus.C1_out <= c1mem[bus.C1_addr];
        if (bus.rd_K)  bus.K_out  <= kmem[bus.K_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [34:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] host_order(input logic [31:0] w);
`ifdef ENCAP_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Expected stream: every C0 word, then C1, then K; only the final K word is last.
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < C0W; i++) exp_q.push_back({1'b0, 2'd0, host_order(c0mem[i])});
        for (int i = 0; i < C1_WORDS; i++) exp_q.push_back({1'b0, 2'd1, host_order(c1mem[i])});
        for (int i = 0; i < K_WORDS; i++) exp_q.push_back({i == K_WORDS - 1, 2'd2, host_order(kmem[i])});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd"}, 64'({bus.rd_C0, bus.rd_C1, bus.rd_K}), 64'd0);
        chk({tag, "_addr"}, 64'({bus.C0_addr, bus.C1_addr, bus.K_addr}), 64'd0);
        chk({tag, "_stream"}, 64'({bus.dout, bus.dout_valid, bus.dout_sel, bus.dout_last}), 64'd0);
    endtask

    // mode: 0 ready high, 1 ready random 50%, 2 ready low for 20 cycles then high
    task automatic run(input int mode, input int restart_at, input int reset_at,
                       output logic [31:0] first_data);
        int first_k = -1, last_hs_k = -1, done_k = -1, n_done = 0, got = 0;
        int rd_stall = 0, multi_rd = 0;
        bit stalled = 0;
        logic [34:0] held, now_w, exp_w;
        first_data = '0;
        build_expected();
        bus.dout_ready = (mode == 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        #1;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (mode == 2 && (bus.rd_C0 | bus.rd_C1 | bus.rd_K)) rd_stall++;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            bus.dout_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k > 20);
            start = (k == restart_at);
            if (k == reset_at) begin
                chk("no_done_before_reset", 64'(n_done), 64'd0);
                rst_n = 1'b0;
                #1;
                chk_outputs_zero("midreset");
                @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    chk("post_reset_idle", 64'({busy, done, bus.dout_valid}), 64'd0);
                end
                return;
            end
            #1;
            now_w = {bus.dout_last, bus.dout_sel, bus.dout};
            if ($countones({bus.rd_C0, bus.rd_C1, bus.rd_K}) > 1) multi_rd++;
            if (mode == 2 && k <= 20 && (bus.rd_C0 | bus.rd_C1 | bus.rd_K)) rd_stall++;
            if (stalled) begin
                chk("stall_valid", 64'(bus.dout_valid), 64'd1);
                chk("stall_hold", 64'(now_w), 64'(held));
            end
            if (bus.dout_valid && first_k < 0) begin
                first_k = k;
                first_data = bus.dout;
            end
            if (done) begin
                n_done++;
                if (done_k < 0) done_k = k;
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) chk("word_count_overrun", 64'(got + 1), 64'(NW));
                else begin
                    exp_w = exp_q.pop_front();
                    chk("word", 64'(now_w), 64'(exp_w));
                end
                got++;
                last_hs_k = k;
            end
            stalled = bus.dout_valid && !bus.dout_ready;
            held = now_w;
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        start = 1'b0;
        chk("first_valid_latency", 64'(first_k), 64'd2);
        chk("word_count", 64'(got), 64'(NW));
        chk("done_count", 64'(n_done), 64'd1);
        chk("done_after_last", 64'(done_k), 64'(last_hs_k + 1));
        chk("rd_onehot", 64'(multi_rd), 64'd0);
        if (mode == 2) chk("stall_reads_le2", 64'(rd_stall <= 2), 64'd1);
    endtask

    logic [31:0] fd;

    initial begin
        for (int i = 0; i < C0W; i++) c0mem[i] = 32'hC000_0000 + 32'(i);
        for (int i = 0; i < C1_WORDS; i++) c1mem[i] = 32'hC100_0000 + 32'(i);
        for (int i = 0; i < K_WORDS; i++) kmem[i] = 32'h4B00_0000 + 32'(i);
`ifdef ENCAP_READER_BSWAP_EN
        c0mem[0] = 32'h1122_3344;
`endif
        bus.dout_ready = 1'b0;
        bus.C0_out = '0;
        bus.C1_out = '0;
        bus.K_out  = '0;
        #1;
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        run(0, 0, 0, fd);
`ifdef ENCAP_READER_BSWAP_EN
        chk("bswap_first", 64'(fd), 64'h4433_2211);
`else
        chk("first_word", 64'(fd), 64'hC000_0000);
`endif
        run(1, 0, 0, fd);
        run(2, 0, 0, fd);
        run(0, 0, 28, fd);
        run(0, 0, 0, fd);
        chk("restart_after_reset_first", 64'(fd), 64'(host_order(c0mem[0])));

        for (int i = 0; i < C0W; i++) c0mem[i] = $urandom;
        for (int i = 0; i < C1_WORDS; i++) c1mem[i] = $urandom;
        for (int i = 0; i < K_WORDS; i++) kmem[i] = $urandom;
        run(0, 10, 0, fd);
        run(1, 5, 0, fd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
